regfile16_onehot_wr: RTL and testbench

- 16-entry register file for the CPU datapath.
- Sits directly downstream of the 4-to-16 write-address decoder and consumes its one-hot word directly as per-register write enables.
- Provides two combinational read ports with same-cycle write-to-read forwarding.
- Flags illegal multi-hot write selects with a sticky error bit.

---
 rtl/cpu_regfile_pkg.sv | 11 +
 rtl/regfile16_onehot_wr_encode.sv | 30 +++
 rtl/regfile16_onehot_wr.sv | 87 ++++++++
 tb/tb_regfile16_onehot_wr.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_regfile_pkg.sv
// Shared constants and types for the CPU register file and its write-select encoder.
package cpu_regfile_pkg;

  localparam int NUM_REGS   = 16;
  localparam int REG_ADDR_W = 4;
  localparam logic [7:0] WCOUNT_MAX = 8'd255;

  typedef logic [NUM_REGS-1:0]   wsel_t;
  typedef logic [REG_ADDR_W-1:0] regaddr_t;

endpackage

// File: rtl/regfile16_onehot_wr_encode.sv
// Encodes the decoder's one-hot write select into an index and classifies it
// as empty, exactly one-hot, or multi-hot (neither flag set).
module onehot16_encode
  import cpu_regfile_pkg::*;
(
  input  wsel_t    i_wsel,
  output regaddr_t o_index,
  output logic     o_is_zero,
  output logic     o_is_onehot
);

  logic [4:0] w_popCount;

  // OR-ing indices is only meaningful when exactly one bit is set, which is
  // the only case where the index is consumed.
  always_comb begin
    w_popCount = '0;
    o_index    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_wsel[i]) begin
        w_popCount = w_popCount + 5'd1;
        o_index    = o_index | regaddr_t'(i);
      end
    end
  end

  assign o_is_zero   = (i_wsel == '0);
  assign o_is_onehot = (w_popCount == 5'd1);

endmodule

// File: rtl/regfile16_onehot_wr.sv
// 16-entry register file written by a one-hot select, with two combinational
// read ports, same-cycle write forwarding and a sticky multi-hot error flag.
module regfile16_onehot_wr
  import cpu_regfile_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit ZERO_REG = 1'b1
)(
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             WE,
  input  wsel_t            WSEL,
  input  logic [WIDTH-1:0] WDATA,
  input  regaddr_t         RA_ADDR,
  input  regaddr_t         RB_ADDR,
  output logic [WIDTH-1:0] RA_DATA,
  output logic [WIDTH-1:0] RB_DATA,
  output logic             WERR,
  output logic [7:0]       WCOUNT
);

  logic [WIDTH-1:0] r_regs [NUM_REGS];
  logic             r_werr;
  logic [7:0]       r_wcount;

  regaddr_t w_idx;
  logic     w_isZero;
  logic     w_isOnehot;
  logic     w_legal;
  logic     w_illegal;

  onehot16_encode u_encode (
    .i_wsel      (WSEL),
    .o_index     (w_idx),
    .o_is_zero   (w_isZero),
    .o_is_onehot (w_isOnehot)
  );

  // Gating with RESET_N keeps forwarding from leaking WDATA while reset is held.
  assign w_legal   = WE & w_isOnehot & RESET_N;
  assign w_illegal = WE & ~w_isOnehot & ~w_isZero;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_werr   <= 1'b0;
      r_wcount <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_legal && WSEL[i] && !(ZERO_REG && i == 0)) begin
          r_regs[i] <= WDATA;
        end
      end
      if (w_illegal) begin
        r_werr <= 1'b1;
      end
      if (w_legal && r_wcount != WCOUNT_MAX) begin
        r_wcount <= r_wcount + 8'd1;
      end
    end
  end

  // The zero-register override is applied last so it also wins over forwarding.
  always_comb begin
    RA_DATA = r_regs[RA_ADDR];
    if (w_legal && w_idx == RA_ADDR) begin
      RA_DATA = WDATA;
    end
    if (ZERO_REG && RA_ADDR == '0) begin
      RA_DATA = '0;
    end

    RB_DATA = r_regs[RB_ADDR];
    if (w_legal && w_idx == RB_ADDR) begin
      RB_DATA = WDATA;
    end
    if (ZERO_REG && RB_ADDR == '0) begin
      RB_DATA = '0;
    end
  end

  assign WERR   = r_werr;
  assign WCOUNT = r_wcount;

endmodule

// File: tb/tb_regfile16_onehot_wr.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops
// and compares them against the read ports and status outputs.
module tb_regfile16_onehot_wr;

  logic        CLK;
  logic        RESET_N;
  logic        WE;
  logic [15:0] WSEL;
  logic [15:0] WDATA;
  logic [3:0]  RA_ADDR;
  logic [3:0]  RB_ADDR;
  logic [15:0] RA_DATA;
  logic [15:0] RB_DATA;
  logic        WERR;
  logic [7:0]  WCOUNT;

  typedef struct {
    string       name;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        werr;
    logic [7:0]  wcount;
  } exp_t;

  exp_t expQ[$];
  event sampleEv;
  int   checks = 0;
  int   errors = 0;

  regfile16_onehot_wr #(
    .WIDTH    (16),
    .ZERO_REG (1'b1)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .WE      (WE),
    .WSEL    (WSEL),
    .WDATA   (WDATA),
    .RA_ADDR (RA_ADDR),
    .RB_ADDR (RB_ADDR),
    .RA_DATA (RA_DATA),
    .RB_DATA (RB_DATA),
    .WERR    (WERR),
    .WCOUNT  (WCOUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic we, input logic [15:0] wsel,
                               input logic [15:0] wdata,
                               input logic [3:0] ra, input logic [3:0] rb);
    WE      = we;
    WSEL    = wsel;
    WDATA   = wdata;
    RA_ADDR = ra;
    RB_ADDR = rb;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] ra,
                             input logic [15:0] rb, input logic werr,
                             input logic [7:0] wcount);
    exp_t e;
    e.name   = name;
    e.ra     = ra;
    e.rb     = rb;
    e.werr   = werr;
    e.wcount = wcount;
    #1;
    expQ.push_back(e);
    -> sampleEv;
    #1;
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  initial begin
    exp_t e;
    forever begin
      @(sampleEv);
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        checks++;
        if (RA_DATA !== e.ra) begin
          errors++;
          $display("[TB] FAIL %s.ra got %h want %h", e.name, RA_DATA, e.ra);
        end
        checks++;
        if (RB_DATA !== e.rb) begin
          errors++;
          $display("[TB] FAIL %s.rb got %h want %h", e.name, RB_DATA, e.rb);
        end
        checks++;
        if (WERR !== e.werr) begin
          errors++;
          $display("[TB] FAIL %s.werr got %b want %b", e.name, WERR, e.werr);
        end
        checks++;
        if (WCOUNT !== e.wcount) begin
          errors++;
          $display("[TB] FAIL %s.wcount got %0d want %0d", e.name, WCOUNT, e.wcount);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RESET_N = 1'b0;
    applyStimulus(1'b0, 16'h0000, 16'h0000, 4'd0, 4'd0);
    step();
    step();
    RESET_N = 1'b1;

    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b0, 16'h0000, 16'h0000, 4'(a), 4'(15 - a));
      checkOutput("rstRead", 16'h0000, 16'h0000, 1'b0, 8'd0);
    end

    step();
    applyStimulus(1'b1, 16'h0020, 16'hBEEF, 4'd5, 4'd5);
    checkOutput("fwdR5", 16'hBEEF, 16'hBEEF, 1'b0, 8'd0);
    step();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 4'd5, 4'd4);
    checkOutput("storedR5", 16'hBEEF, 16'h0000, 1'b0, 8'd1);

    applyStimulus(1'b1, 16'h0001, 16'h1234, 4'd0, 4'd5);
    checkOutput("r0Fwd", 16'h0000, 16'hBEEF, 1'b0, 8'd1);
    step();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 4'd0, 4'd5);
    checkOutput("r0After", 16'h0000, 16'hBEEF, 1'b0, 8'd2);

    applyStimulus(1'b1, 16'h0000, 16'h7777, 4'd5, 4'd0);
    checkOutput("nullWr", 16'hBEEF, 16'h0000, 1'b0, 8'd2);
    step();
    applyStimulus(1'b0, 16'hFFFF, 16'h7777, 4'd5, 4'd6);
    checkOutput("gatedWr", 16'hBEEF, 16'h0000, 1'b0, 8'd2);
    step();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 4'd5, 4'd6);
    checkOutput("gatedAfter", 16'hBEEF, 16'h0000, 1'b0, 8'd2);

    applyStimulus(1'b1, 16'h0008, 16'h00AA, 4'd3, 4'd4);
    checkOutput("preloadR3", 16'h00AA, 16'h0000, 1'b0, 8'd2);
    step();
    applyStimulus(1'b1, 16'h0018, 16'hFFFF, 4'd3, 4'd4);
    checkOutput("illegalWr", 16'h00AA, 16'h0000, 1'b0, 8'd3);
    step();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 4'd3, 4'd4);
    checkOutput("illegalAfter", 16'h00AA, 16'h0000, 1'b1, 8'd3);

    applyStimulus(1'b1, 16'h0200, 16'h5A5A, 4'd9, 4'd3);
    checkOutput("stickyFwd", 16'h5A5A, 16'h00AA, 1'b1, 8'd3);
    step();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 4'd9, 4'd3);
    checkOutput("stickyAfter", 16'h5A5A, 16'h00AA, 1'b1, 8'd4);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 16'h0080, 16'(i), 4'd7, 4'd9);
      step();
    end
    applyStimulus(1'b0, 16'h0000, 16'h0000, 4'd7, 4'd9);
    checkOutput("saturate", 16'd299, 16'h5A5A, 1'b1, 8'd255);

    #1;
    RESET_N = 1'b0;
    checkOutput("asyncRst", 16'h0000, 16'h0000, 1'b0, 8'd0);
    step();
    applyStimulus(1'b1, 16'h0080, 16'h1111, 4'd7, 4'd9);
    checkOutput("rstWrFwd", 16'h0000, 16'h0000, 1'b0, 8'd0);
    step();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 4'd7, 4'd9);
    checkOutput("rstWrHeld", 16'h0000, 16'h0000, 1'b0, 8'd0);
    RESET_N = 1'b1;
    step();
    checkOutput("rstRelease", 16'h0000, 16'h0000, 1'b0, 8'd0);

    #5;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboardDrain got %0d want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
